// File: rtl/clock_pkg.sv
// Shared time-of-day widths, constants and alarm state encoding used by
// the clock counter and its downstream alarm logic.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int SEC_PER_MIN   = 60;
    localparam int MIN_PER_HOUR  = 60;
    localparam int HOURS_PER_DAY = 24;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Wide enough for the longest snooze (15 minutes of seconds).
    localparam int SNZ_W = $clog2(15 * 60 + 1);

    function automatic logic time_valid(input logic [MIN_W-1:0]  m,
                                        input logic [HOUR_W-1:0] h);
        return (m < MIN_W'(MIN_PER_HOUR)) && (h < HOUR_W'(HOURS_PER_DAY));
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter: decrements once per sec_tick, stops at zero,
// and flags the tick on which it reaches zero.
module sec_countdown
    import clock_pkg::*;
#(
    parameter int W = SNZ_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sec_tick,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear beats load beats decrement.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (load) begin
            count_d = load_val;
        end else if (sec_tick && (count_q != {W{1'b0}})) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero   = (count_q == {W{1'b0}});
    assign expire = sec_tick && (count_q == W'(1));

endmodule

// File: rtl/alarm_unit.sv
// Single programmable alarm: matches hour:minute from the clock counter, rings
// with a buzzer square wave, and supports bounded snooze, dismiss and timeout.
module alarm_unit
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [SEC_W-1:0]  time_sec,
    input  logic [MIN_W-1:0]  time_min,
    input  logic [HOUR_W-1:0] time_hour,
    input  logic              set_en,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic              arm,
    input  logic              disarm,
    input  logic              snooze,
    input  logic              dismiss,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic              armed,
    output logic              ringing,
    output logic              snooze_active,
    output logic [1:0]        snooze_count,
    output logic              buzzer,
    output logic              set_err
);

    localparam logic [SNZ_W-1:0] SNZ_LOAD   = SNZ_W'(SNOOZE_MIN * SEC_PER_MIN);
    localparam logic [7:0]       RING_LIMIT = 8'(RING_TIMEOUT_S);
    localparam logic [1:0]       SNZ_MAX    = 2'(MAX_SNOOZE);

    alarm_state_t      state_q, state_d;
    logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
    logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
    logic              match_prev_q, match_prev_d;
    logic [7:0]        ring_cnt_q, ring_cnt_d;
    logic [1:0]        snooze_count_q, snooze_count_d;
    logic              buzzer_q, buzzer_d;
    logic              set_err_q, set_err_d;
    logic              armed_q, ringing_q, snooze_active_q;

    logic       match_now, trigger, set_allowed;
    logic [7:0] ring_inc;
    logic       ring_expire;
    logic       snz_load, snz_clr, snz_zero, snz_expire;

    // Seconds are irrelevant to an hour:minute alarm.
    logic unused_time_sec;
    assign unused_time_sec = ^time_sec;

    assign match_now   = (time_hour == alarm_hour_q) && (time_min == alarm_min_q);
    assign trigger     = match_now && !match_prev_q;
    assign set_allowed = (state_q == IDLE) || (state_q == ARMED);
    assign ring_inc    = (ring_cnt_q == 8'hFF) ? ring_cnt_q : ring_cnt_q + 8'd1;
    assign ring_expire = sec_tick && (ring_inc >= RING_LIMIT);

    sec_countdown #(.W(SNZ_W)) u_snz_cnt (
        .clk      (clk),
        .reset    (reset),
        .sec_tick (sec_tick),
        .load     (snz_load),
        .clr      (snz_clr),
        .load_val (SNZ_LOAD),
        .zero     (snz_zero),
        .expire   (snz_expire)
    );

    // Alarm-time writes and edge detection of the hour:minute match.
    always_comb begin
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        set_err_d    = 1'b0;
        match_prev_d = match_now;
        if (set_en && set_allowed) begin
            if (time_valid(set_min, set_hour)) begin
                alarm_min_d  = set_min;
                alarm_hour_d = set_hour;
                // Writing the current time must not fire this minute.
                match_prev_d = 1'b1;
            end else begin
                set_err_d = 1'b1;
            end
        end else begin
            set_err_d = 1'b0;
        end
    end

    // Alarm state transitions in priority disarm > dismiss > snooze > expiry > trigger > arm.
    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snooze_count_d = snooze_count_q;
        buzzer_d       = buzzer_q;
        snz_load       = 1'b0;
        snz_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                buzzer_d = 1'b0;
                if (arm) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                buzzer_d = 1'b0;
                if (disarm) begin
                    state_d = IDLE;
                end else if (trigger) begin
                    state_d        = RINGING;
                    ring_cnt_d     = 8'd0;
                    snooze_count_d = 2'd0;
                end else begin
                    state_d = ARMED;
                end
            end
            RINGING: begin
                if (disarm) begin
                    state_d  = IDLE;
                    buzzer_d = 1'b0;
                end else if (dismiss) begin
                    state_d        = ARMED;
                    snooze_count_d = 2'd0;
                    buzzer_d       = 1'b0;
                end else if (snooze && (snooze_count_q < SNZ_MAX)) begin
                    state_d        = SNOOZE;
                    snooze_count_d = snooze_count_q + 2'd1;
                    snz_load       = 1'b1;
                    buzzer_d       = 1'b0;
                end else if (ring_expire) begin
                    state_d        = ARMED;
                    snooze_count_d = 2'd0;
                    buzzer_d       = 1'b0;
                end else if (sec_tick) begin
                    ring_cnt_d = ring_inc;
                    buzzer_d   = ~buzzer_q;
                end else begin
                    state_d = RINGING;
                end
            end
            SNOOZE: begin
                buzzer_d = 1'b0;
                if (disarm) begin
                    state_d = IDLE;
                    snz_clr = 1'b1;
                end else if (dismiss) begin
                    state_d        = ARMED;
                    snooze_count_d = 2'd0;
                    snz_clr        = 1'b1;
                end else if (snz_expire || snz_zero) begin
                    state_d    = RINGING;
                    ring_cnt_d = 8'd0;
                end else begin
                    state_d = SNOOZE;
                end
            end
            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
                snz_clr  = 1'b1;
            end
        endcase
    end

    // State, alarm time and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            alarm_min_q     <= {MIN_W{1'b0}};
            alarm_hour_q    <= {HOUR_W{1'b0}};
            match_prev_q    <= 1'b0;
            ring_cnt_q      <= 8'd0;
            snooze_count_q  <= 2'd0;
            buzzer_q        <= 1'b0;
            set_err_q       <= 1'b0;
            armed_q         <= 1'b0;
            ringing_q       <= 1'b0;
            snooze_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            alarm_min_q     <= alarm_min_d;
            alarm_hour_q    <= alarm_hour_d;
            match_prev_q    <= match_prev_d;
            ring_cnt_q      <= ring_cnt_d;
            snooze_count_q  <= snooze_count_d;
            buzzer_q        <= buzzer_d;
            set_err_q       <= set_err_d;
            armed_q         <= (state_d != IDLE);
            ringing_q       <= (state_d == RINGING);
            snooze_active_q <= (state_d == SNOOZE);
        end
    end

    assign alarm_min     = alarm_min_q;
    assign alarm_hour    = alarm_hour_q;
    assign armed         = armed_q;
    assign ringing       = ringing_q;
    assign snooze_active = snooze_active_q;
    assign snooze_count  = snooze_count_q;
    assign buzzer        = buzzer_q;
    assign set_err       = set_err_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit with a 1-minute snooze,
// 10-second ring timeout and two snoozes per event.
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [5:0] time_sec, time_min;
    logic [4:0] time_hour;
    logic       set_en;
    logic [5:0] set_min;
    logic [4:0] set_hour;
    logic       arm, disarm, snooze, dismiss;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       armed, ringing, snooze_active, buzzer, set_err;
    logic [1:0] snooze_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alarm_unit #(.SNOOZE_MIN(1), .RING_TIMEOUT_S(10), .MAX_SNOOZE(2)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .time_sec(time_sec), .time_min(time_min), .time_hour(time_hour),
        .set_en(set_en), .set_min(set_min), .set_hour(set_hour),
        .arm(arm), .disarm(disarm), .snooze(snooze), .dismiss(dismiss),
        .alarm_min(alarm_min), .alarm_hour(alarm_hour), .armed(armed),
        .ringing(ringing), .snooze_active(snooze_active),
        .snooze_count(snooze_count), .buzzer(buzzer), .set_err(set_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_sec();
        if (time_sec == 6'd59) begin
            time_sec = 6'd0;
            if (time_min == 6'd59) begin
                time_min  = 6'd0;
                time_hour = (time_hour == 5'd23) ? 5'd0 : time_hour + 5'd1;
            end else begin
                time_min = time_min + 6'd1;
            end
        end else begin
            time_sec = time_sec + 6'd1;
        end
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        time_hour = h;
        time_min  = m;
        time_sec  = s;
        step();
        step();
    endtask

    task automatic write_alarm(input logic [4:0] h, input logic [5:0] m);
        set_hour = h;
        set_min  = m;
        set_en   = 1'b1;
        step();
        set_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({alarm_min, alarm_hour, armed, ringing, snooze_active, snooze_count, buzzer, set_err} !== 18'd0) begin
            errors++;
            $display("FAIL reset_held: outputs=%h expected 0", {alarm_min, alarm_hour, armed, ringing,
                     snooze_active, snooze_count, buzzer, set_err});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({alarm_min, alarm_hour, armed, ringing, snooze_active, snooze_count, buzzer, set_err} !== 18'd0) begin
            errors++;
            $display("FAIL reset_released: outputs=%h expected 0", {alarm_min, alarm_hour, armed, ringing,
                     snooze_active, snooze_count, buzzer, set_err});
        end
    endtask

    task automatic test_set_range();
        write_alarm(5'd7, 6'd60);
        checks++;
        if (set_err !== 1'b1 || alarm_min !== 6'd0) begin
            errors++;
            $display("FAIL set_min60: set_err=%0b alarm_min=%0d expected 1/0", set_err, alarm_min);
        end
        step();
        checks++;
        if (set_err !== 1'b0) begin
            errors++;
            $display("FAIL set_err_pulse: set_err=%0b expected 0", set_err);
        end
        write_alarm(5'd24, 6'd10);
        checks++;
        if (set_err !== 1'b1 || alarm_hour !== 5'd0 || alarm_min !== 6'd0) begin
            errors++;
            $display("FAIL set_hour24: set_err=%0b alarm=%0d:%0d expected 1 0:0", set_err, alarm_hour, alarm_min);
        end
        write_alarm(5'd7, 6'd30);
        checks++;
        if (set_err !== 1'b0 || alarm_hour !== 5'd7 || alarm_min !== 6'd30) begin
            errors++;
            $display("FAIL set_valid: set_err=%0b alarm=%0d:%0d expected 0 7:30", set_err, alarm_hour, alarm_min);
        end
    endtask

    task automatic test_ring_timeout();
        set_time(5'd7, 6'd29, 6'd50);
        arm = 1'b1;
        step();
        arm = 1'b0;
        checks++;
        if (armed !== 1'b1 || ringing !== 1'b0) begin
            errors++;
            $display("FAIL arm: armed=%0b ringing=%0b expected 1/0", armed, ringing);
        end
        for (int i = 0; i < 9; i++) tick_sec();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL early_ring: ringing=%0b expected 0 at 07:29:59", ringing);
        end
        tick_sec();
        checks++;
        if (ringing !== 1'b1 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL trigger: ringing=%0b buzzer=%0b expected 1/0", ringing, buzzer);
        end
        for (int i = 1; i <= 9; i++) begin
            tick_sec();
            checks++;
            if (ringing !== 1'b1 || buzzer !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL buzzer_tick%0d: ringing=%0b buzzer=%0b expected 1/%0b", i, ringing, buzzer, (i % 2) == 1);
            end
        end
        tick_sec();
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b1 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL timeout: ringing=%0b armed=%0b buzzer=%0b expected 0/1/0", ringing, armed, buzzer);
        end
    endtask

    task automatic test_snooze();
        write_alarm(5'd7, 6'd31);
        for (int i = 0; i < 49; i++) tick_sec();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL pre_0731: ringing=%0b expected 0", ringing);
        end
        tick_sec();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL ring_0731: ringing=%0b expected 1", ringing);
        end
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checks++;
        if (snooze_active !== 1'b1 || snooze_count !== 2'd1 || ringing !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL snooze1: snz=%0b cnt=%0d ringing=%0b armed=%0b expected 1/1/0/1",
                     snooze_active, snooze_count, ringing, armed);
        end
        for (int i = 0; i < 59; i++) tick_sec();
        checks++;
        if (snooze_active !== 1'b1 || ringing !== 1'b0) begin
            errors++;
            $display("FAIL snooze_59: snz=%0b ringing=%0b expected 1/0", snooze_active, ringing);
        end
        tick_sec();
        checks++;
        if (ringing !== 1'b1 || snooze_active !== 1'b0 || snooze_count !== 2'd1) begin
            errors++;
            $display("FAIL snooze_end: ringing=%0b snz=%0b cnt=%0d expected 1/0/1", ringing, snooze_active, snooze_count);
        end
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checks++;
        if (snooze_active !== 1'b1 || snooze_count !== 2'd2) begin
            errors++;
            $display("FAIL snooze2: snz=%0b cnt=%0d expected 1/2", snooze_active, snooze_count);
        end
        for (int i = 0; i < 60; i++) tick_sec();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checks++;
        if (ringing !== 1'b1 || snooze_active !== 1'b0 || snooze_count !== 2'd2) begin
            errors++;
            $display("FAIL snooze3_ignored: ringing=%0b snz=%0b cnt=%0d expected 1/0/2", ringing, snooze_active, snooze_count);
        end
        write_alarm(5'd7, 6'd60);
        checks++;
        if (set_err !== 1'b0) begin
            errors++;
            $display("FAIL set_in_ring_err: set_err=%0b expected 0", set_err);
        end
        write_alarm(5'd8, 6'd0);
        checks++;
        if (alarm_hour !== 5'd7 || alarm_min !== 6'd31 || set_err !== 1'b0) begin
            errors++;
            $display("FAIL set_in_ring: alarm=%0d:%0d set_err=%0b expected 7:31 0", alarm_hour, alarm_min, set_err);
        end
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        checks++;
        if (armed !== 1'b1 || ringing !== 1'b0 || snooze_count !== 2'd0 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL dismiss: armed=%0b ringing=%0b cnt=%0d buzzer=%0b expected 1/0/0/0",
                     armed, ringing, snooze_count, buzzer);
        end
    endtask

    task automatic test_no_retrigger();
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL disarm: armed=%0b expected 0", armed);
        end
        write_alarm(5'd7, 6'd40);
        set_time(5'd7, 6'd40, 6'd20);
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) tick_sec();
        checks++;
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_in_minute: ringing=%0b armed=%0b expected 0/1", ringing, armed);
        end
        set_time(5'd7, 6'd41, 6'd0);
        write_alarm(5'd7, 6'd41);
        for (int i = 0; i < 5; i++) tick_sec();
        checks++;
        if (ringing !== 1'b0 || alarm_min !== 6'd41) begin
            errors++;
            $display("FAIL write_current: ringing=%0b alarm_min=%0d expected 0/41", ringing, alarm_min);
        end
    endtask

    task automatic test_disarm_snooze_same();
        write_alarm(5'd7, 6'd42);
        set_time(5'd7, 6'd41, 6'd59);
        tick_sec();
        tick_sec();
        checks++;
        if (ringing !== 1'b1 || buzzer !== 1'b1) begin
            errors++;
            $display("FAIL ring_0742: ringing=%0b buzzer=%0b expected 1/1", ringing, buzzer);
        end
        disarm = 1'b1;
        snooze = 1'b1;
        step();
        disarm = 1'b0;
        snooze = 1'b0;
        checks++;
        if (armed !== 1'b0 || ringing !== 1'b0 || snooze_active !== 1'b0 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL disarm_snooze: armed=%0b ringing=%0b snz=%0b buzzer=%0b expected 0/0/0/0",
                     armed, ringing, snooze_active, buzzer);
        end
    endtask

    task automatic test_reset_mid_snooze();
        logic rang;
        write_alarm(5'd7, 6'd43);
        arm = 1'b1;
        step();
        arm = 1'b0;
        set_time(5'd7, 6'd42, 6'd59);
        tick_sec();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        for (int i = 0; i < 5; i++) tick_sec();
        checks++;
        if (snooze_active !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_snooze: snz=%0b expected 1", snooze_active);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({alarm_min, alarm_hour, armed, ringing, snooze_active, snooze_count, buzzer, set_err} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h expected 0", {alarm_min, alarm_hour, armed, ringing,
                     snooze_active, snooze_count, buzzer, set_err});
        end
        step();
        reset = 1'b0;
        step();
        rang = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick_sec();
            rang = rang | ringing | snooze_active | armed;
        end
        checks++;
        if (rang !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: activity=%0b expected 0", rang);
        end
    endtask

    initial begin
        reset     = 1'b1;
        sec_tick  = 1'b0;
        time_sec  = 6'd0;
        time_min  = 6'd0;
        time_hour = 5'd0;
        set_en    = 1'b0;
        set_min   = 6'd0;
        set_hour  = 5'd0;
        arm       = 1'b0;
        disarm    = 1'b0;
        snooze    = 1'b0;
        dismiss   = 1'b0;
        test_reset();
        test_set_range();
        test_ring_timeout();
        test_snooze();
        test_no_retrigger();
        test_disarm_snooze_same();
        test_reset_mid_snooze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Consumes the time-of-day outputs (seconds/minutes/hours) and the one-second tick of the digital clock counter.
- Holds one programmable alarm time and raises a ringing indication with a buzzer drive when the time matches.
- Supports snooze with a bounded repeat count, dismiss, and an auto-stop timeout.
- Sits directly downstream of the clock counter; feeds the display/buzzer stage.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1..15)
RING_TIMEOUT_S, 60, ringing auto-stops after this many sec_tick pulses (1..255)
MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sec_tick  in  1  one-clk pulse per second from the clock counter
time_sec  in  6  current seconds, 0..59
time_min  in  6  current minutes, 0..59
time_hour  in  5  current hours, 0..23
set_en  in  1  one-cycle strobe: load set_min/set_hour as the alarm time
set_min  in  6  new alarm minute
set_hour  in  5  new alarm hour
arm  in  1  one-cycle strobe: enable alarm
disarm  in  1  one-cycle strobe: disable alarm, stop ringing
snooze  in  1  one-cycle strobe: snooze while ringing
dismiss  in  1  one-cycle strobe: stop ringing, remain armed for next day
alarm_min  out  6  stored alarm minute
alarm_hour  out  5  stored alarm hour
armed  out  1  1 in ARMED, RINGING, SNOOZE
ringing  out  1  1 in RINGING
snooze_active  out  1  1 in SNOOZE
snooze_count  out  2  snoozes used in current event
buzzer  out  1  square wave, toggles on each sec_tick while RINGING
set_err  out  1  one-cycle pulse on a rejected set_en

Behaviour:
- Reset values: all outputs 0; alarm 00:00; state IDLE; match_prev 0; all counters 0.
- All outputs are registered and update on the clk edge following the causing input.
- Set: set_en with set_min<60 and set_hour<24 loads the alarm in IDLE or ARMED.
  - Out-of-range values: alarm unchanged, set_err=1 for one cycle.
  - set_en in RINGING or SNOOZE: ignored, no set_err.
- Match: match_now = (time_hour==alarm_hour) && (time_min==alarm_min).
  - trigger = match_now && !match_prev.
  - match_prev <= match_now every cycle in every state, so arming inside the matching minute does not trigger until the next day.
  - A valid set_en forces match_prev<=1 that cycle, so writing the current hour:minute does not trigger.
- States: IDLE, ARMED, RINGING, SNOOZE. Per-cycle priority: disarm > dismiss > snooze > counter expiry > trigger > arm.
  - IDLE: arm -> ARMED.
  - ARMED: disarm -> IDLE; trigger -> RINGING with ring_cnt=0, snooze_count=0.
  - RINGING:
    - disarm -> IDLE.
    - dismiss -> ARMED, snooze_count=0.
    - snooze with snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count+1; snz_cnt=SNOOZE_MIN*60.
    - snooze with snooze_count==MAX_SNOOZE is ignored.
    - ring_cnt increments per sec_tick; reaching RING_TIMEOUT_S -> ARMED, snooze_count=0.
  - SNOOZE: snz_cnt decrements per sec_tick; reaching 0 -> RINGING, ring_cnt=0. dismiss -> ARMED; disarm -> IDLE.
- arm/snooze/dismiss in states where not listed: no effect.
- buzzer: 0 outside RINGING; cleared on every entry to and exit from RINGING; toggles on each sec_tick while RINGING.
- Widths:
  - snz_cnt is $clog2(15*60+1) bits.
  - ring_cnt is 8 bits, saturating.
  - time inputs are not range-checked; out-of-range values simply never match.
- Reset asserted mid-ring or mid-snooze: immediate return to reset values, including the alarm time.

Decomposition:
- Shared package clock_pkg:
  - alarm_state_t enum (IDLE/ARMED/RINGING/SNOOZE).
  - constants SEC_PER_MIN=60, MIN_PER_HOUR=60, HOURS_PER_DAY=24.
  - field widths SEC_W=6, MIN_W=6, HOUR_W=5.
- One sub-module: sec_countdown.
  - Loadable down-counter, decremented by sec_tick.
  - Provides a zero flag.
  - Used for snz_cnt.

Test Plan:
Use SNOOZE_MIN=1, RING_TIMEOUT_S=10, MAX_SNOOZE=2 unless noted.
- Set 07:30, arm at 07:29:50, tick to 07:30:00 -> ringing=1 the cycle after time_min becomes 30; buzzer toggles each tick; auto-stop after 10 ticks -> ringing=0, armed=1.
- Ringing, snooze -> snooze_active=1, snooze_count=1; 60 ticks later ringing=1. Snooze again -> count=2. Third snooze ignored: ringing stays 1.
- set_en with set_min=60 -> set_err pulses 1 cycle; alarm_min unchanged. set_en in RINGING -> ignored, no set_err.
- Arm at 07:30:20 with alarm 07:30 -> no ring. Write alarm=current time while ARMED -> no ring.
- disarm and snooze in the same cycle while ringing -> IDLE; armed=0, buzzer=0.
- reset mid-SNOOZE -> all outputs 0 and alarm 00:00 within the same cycle; no later ring.
